// File: rtl/ahb_bram_ctrl.sv
// AHB-Lite slave driving port A of a byte-lane block RAM.
// Zero-wait-state reads and writes; a read that lands on a pending write data phase gets one wait state.
module ahb_bram_ctrl #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic [3:0]            HPROT,
    input  logic                  HWRITE,
    input  logic [31:0]           HADDR,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic [31:0]           HRDATA,
    output logic                  HRESP,
    output logic [ADDR_WIDTH-1:0] BRAM_ADDR,
    output logic [31:0]           BRAM_WDATA,
    output logic [3:0]            BRAM_WE,
    input  logic [31:0]           BRAM_RDATA
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WDATA  = 2'd1,
        S_RDATA  = 2'd2,
        S_RSTALL = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [ADDR_WIDTH-1:0] r_raddr;
    logic [3:0]            r_wmask;

    logic                  w_accept;
    logic                  w_ready;
    logic [3:0]            w_mask;
    logic [ADDR_WIDTH-1:0] w_haddr;
    logic                  w_unused;

    assign w_accept = HSEL & HTRANS[1] & HREADY;
    assign w_haddr  = HADDR[ADDR_WIDTH+1:2];
    assign w_ready  = (r_state != S_RSTALL);
    assign w_unused = ^{HPROT, HTRANS[0], HADDR[31:ADDR_WIDTH+2]};

    // Misaligned low address bits are simply ignored for halfword/word sizes
    always_comb begin
        w_mask = 4'b0000;
        case (HSIZE)
            3'd0:    w_mask = 4'b0001 << HADDR[1:0];
            3'd1:    w_mask = HADDR[1] ? 4'b1100 : 4'b0011;
            3'd2:    w_mask = 4'b1111;
            default: w_mask = 4'b0000;
        endcase
    end

    always_comb begin
        w_next = S_IDLE;
        if (r_state == S_RSTALL) begin
            w_next = S_RDATA;
        end else if (w_accept && HWRITE) begin
            w_next = S_WDATA;
        end else if (w_accept && (r_state == S_WDATA)) begin
            w_next = S_RSTALL;
        end else if (w_accept) begin
            w_next = S_RDATA;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= S_IDLE;
            r_waddr <= '0;
            r_raddr <= '0;
            r_wmask <= 4'b0000;
        end else begin
            r_state <= w_next;
            if (w_ready && w_accept && HWRITE) begin
                r_waddr <= w_haddr;
                r_wmask <= w_mask;
            end
            if (w_next == S_RSTALL) begin
                r_raddr <= w_haddr;
            end
        end
    end

    // The RAM port follows the bus address unless a write or a deferred read owns it
    always_comb begin
        HREADYOUT = 1'b1;
        HRDATA    = 32'h0;
        BRAM_ADDR = w_haddr;
        BRAM_WE   = 4'b0000;
        case (r_state)
            S_WDATA: begin
                BRAM_ADDR = r_waddr;
                BRAM_WE   = r_wmask;
            end
            S_RDATA: begin
                HRDATA = BRAM_RDATA;
            end
            S_RSTALL: begin
                BRAM_ADDR = r_raddr;
                HREADYOUT = 1'b0;
            end
            default: begin
                HREADYOUT = 1'b1;
            end
        endcase
    end

    assign BRAM_WDATA = HWDATA;
    assign HRESP      = 1'b0;

endmodule

// File: tb/tb_ahb_bram_ctrl.sv
// Bench for ahb_bram_ctrl: AHB master driver, behavioural RAM, and a byte-array reference model
// that predicts read data, lane enables and wait states for directed and random traffic.
module tb_ahb_bram_ctrl;

    localparam int AW     = 8;
    localparam int NWORDS = 1 << AW;
    localparam int NBYTES = NWORDS * 4;

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic          HSEL;
    logic [1:0]    HTRANS;
    logic [2:0]    HSIZE;
    logic [3:0]    HPROT;
    logic          HWRITE;
    logic [31:0]   HADDR;
    logic [31:0]   HWDATA;
    logic          HREADY;
    logic          HREADYOUT;
    logic [31:0]   HRDATA;
    logic          HRESP;
    logic [AW-1:0] BRAM_ADDR;
    logic [31:0]   BRAM_WDATA;
    logic [3:0]    BRAM_WE;
    logic [31:0]   BRAM_RDATA;

    ahb_bram_ctrl #(.ADDR_WIDTH(AW)) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .HSEL       (HSEL),
        .HTRANS     (HTRANS),
        .HSIZE      (HSIZE),
        .HPROT      (HPROT),
        .HWRITE     (HWRITE),
        .HADDR      (HADDR),
        .HWDATA     (HWDATA),
        .HREADY     (HREADY),
        .HREADYOUT  (HREADYOUT),
        .HRDATA     (HRDATA),
        .HRESP      (HRESP),
        .BRAM_ADDR  (BRAM_ADDR),
        .BRAM_WDATA (BRAM_WDATA),
        .BRAM_WE    (BRAM_WE),
        .BRAM_RDATA (BRAM_RDATA)
    );

    // Single slave on the bus: global ready is this slave's ready
    assign HREADY = HREADYOUT;

    always #5 HCLK = ~HCLK;

    logic [31:0] ram [NWORDS];
    always @(posedge HCLK) begin
        for (int i = 0; i < 4; i++) begin
            if (BRAM_WE[i]) ram[BRAM_ADDR][8*i +: 8] <= BRAM_WDATA[8*i +: 8];
        end
        BRAM_RDATA <= ram[BRAM_ADDR];
    end

    logic [7:0] refmem [NBYTES];

    int n_checks = 0;
    int n_errors = 0;

    bit          pv;
    bit          pw;
    logic [31:0] pa;
    logic [31:0] pd;
    logic [2:0]  ps;
    int          pexp;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Byte lanes a transfer touches, from its size and byte address
    function automatic logic [3:0] lanes(input logic [2:0] size, input logic [31:0] addr);
        logic [3:0] m;
        m = 4'b0000;
        if (size == 3'd0) m[addr[1:0]] = 1'b1;
        else if (size == 3'd1) begin
            m[{addr[1], 1'b0}] = 1'b1;
            m[{addr[1], 1'b1}] = 1'b1;
        end else if (size == 3'd2) m = 4'b1111;
        return m;
    endfunction

    function automatic int word_base(input logic [31:0] addr);
        return int'(addr & 32'(NBYTES - 1)) & ~3;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] addr);
        int b;
        b = word_base(addr);
        return {refmem[b+3], refmem[b+2], refmem[b+1], refmem[b]};
    endfunction

    task automatic ref_write(input logic [2:0] size, input logic [31:0] addr, input logic [31:0] d);
        logic [3:0] m;
        int b;
        m = lanes(size, addr);
        b = word_base(addr);
        for (int i = 0; i < 4; i++) if (m[i]) refmem[b+i] = d[8*i +: 8];
    endtask

    // One address phase; simultaneously completes and checks the previous transfer's data phase
    task automatic issue(input bit sel, input logic [1:0] trans, input bit wr, input logic [2:0] size,
                         input logic [31:0] addr, input logic [31:0] wd);
        int  stalls;
        bit  acc;
        int  nexp;
        HSEL   = sel;
        HTRANS = trans;
        HWRITE = wr;
        HSIZE  = size;
        HADDR  = addr;
        HPROT  = 4'($urandom);
        HWDATA = (pv && pw) ? pd : $urandom;
        stalls = 0;
        @(negedge HCLK);
        while (HREADYOUT !== 1'b1 && stalls < 4) begin
            check_val("we_stall", 32'(BRAM_WE), 32'h0);
            stalls++;
            @(negedge HCLK);
        end
        check_val("wait_states", 32'(stalls), pv ? 32'(pexp) : 32'h0);
        check_val("hresp", 32'(HRESP), 32'h0);
        if (pv && pw) check_val("bram_we", 32'(BRAM_WE), 32'(lanes(ps, pa)));
        else          check_val("bram_we_idle", 32'(BRAM_WE), 32'h0);
        if (pv && !pw) check_val("hrdata", HRDATA, ref_word(pa));
        else           check_val("hrdata_idle", HRDATA, 32'h0);
        @(posedge HCLK);
        if (pv && pw) ref_write(ps, pa, pd);
        #1;
        acc  = sel && trans[1];
        nexp = (acc && !wr && pv && pw) ? 1 : 0;
        pv   = acc;
        pw   = wr;
        pa   = addr;
        ps   = size;
        pd   = wd;
        pexp = nexp;
    endtask

    task automatic idle();
        issue(1'b0, 2'b00, 1'b0, 3'd2, 32'h0, 32'h0);
    endtask

    task automatic reset_mid_write(input logic [31:0] addr, input logic [31:0] d);
        issue(1'b1, 2'b10, 1'b1, 3'd2, addr, d);
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWDATA = d;
        @(negedge HCLK);
        check_val("rst_we_before", 32'(BRAM_WE), 32'hF);
        #2 HRESETn = 1'b0;
        #1;
        check_val("rst_we", 32'(BRAM_WE), 32'h0);
        check_val("rst_hreadyout", 32'(HREADYOUT), 32'h1);
        check_val("rst_hrdata", HRDATA, 32'h0);
        check_val("rst_hresp", 32'(HRESP), 32'h0);
        @(posedge HCLK);
        #1 HRESETn = 1'b1;
        pv = 1'b0;
    endtask

    initial begin
        pv = 1'b0; pw = 1'b0; pa = '0; pd = '0; ps = '0; pexp = 0;
        HRESETn = 1'b0;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'd2;
        HPROT = 4'h0; HADDR = '0; HWDATA = '0;
        for (int i = 0; i < NBYTES; i++) refmem[i] = 8'h00;
        #12;
        check_val("reset_hreadyout", 32'(HREADYOUT), 32'h1);
        check_val("reset_hrdata", HRDATA, 32'h0);
        check_val("reset_we", 32'(BRAM_WE), 32'h0);
        check_val("reset_hresp", 32'(HRESP), 32'h0);
        @(posedge HCLK);
        #1 HRESETn = 1'b1;

        // Preload every word so later reads are fully defined
        for (int i = 0; i < NWORDS; i++) issue(1'b1, 2'b10, 1'b1, 3'd2, 32'(i * 4), $urandom);
        idle();

        issue(1'b1, 2'b10, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
        idle();
        issue(1'b1, 2'b10, 1'b0, 3'd2, 32'h10, 32'h0);
        idle();

        issue(1'b1, 2'b10, 1'b1, 3'd2, 32'h20, 32'h11223344);
        issue(1'b1, 2'b10, 1'b1, 3'd0, 32'h21, 32'h0000AA00);
        issue(1'b1, 2'b10, 1'b1, 3'd1, 32'h22, 32'hBBCC0000);
        idle();
        issue(1'b1, 2'b10, 1'b0, 3'd2, 32'h20, 32'h0);
        idle();

        issue(1'b1, 2'b10, 1'b1, 3'd2, 32'h40, 32'h5A5A5A5A);
        issue(1'b1, 2'b10, 1'b0, 3'd2, 32'h40, 32'h0);
        idle();

        for (int i = 0; i < 4; i++) issue(1'b1, 2'b11, 1'b1, 3'd2, 32'(i * 4), 32'(i));
        for (int i = 0; i < 4; i++) issue(1'b1, 2'b11, 1'b0, 3'd2, 32'(i * 4), 32'h0);
        idle();

        for (int i = 0; i < 4; i++) begin
            issue(1'b1, 2'b10, 1'b1, 3'd2, 32'(i * 4), 32'hC0DE0000 | 32'(i));
            issue(1'b1, 2'b10, 1'b0, 3'd2, 32'(i * 4), 32'h0);
        end
        idle();

        issue(1'b1, 2'b10, 1'b1, 3'd3, 32'h50, 32'hFFFFFFFF);
        idle();
        issue(1'b0, 2'b10, 1'b1, 3'd2, 32'h50, 32'hEEEEEEEE);
        issue(1'b1, 2'b01, 1'b1, 3'd2, 32'h50, 32'hDDDDDDDD);
        issue(1'b1, 2'b10, 1'b0, 3'd2, 32'h50, 32'h0);
        idle();

        issue(1'b1, 2'b10, 1'b1, 3'd2, 32'h60, 32'h12345678);
        idle();
        reset_mid_write(32'h60, 32'hCAFEF00D);
        issue(1'b1, 2'b10, 1'b0, 3'd2, 32'h60, 32'h0);
        idle();

        for (int k = 0; k < 600; k++) begin
            logic [31:0] a;
            logic [2:0]  sz;
            a  = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
            sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            issue($urandom_range(0, 7) != 0, 2'($urandom), 1'($urandom), sz, a, $urandom);
        end
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
